// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: level req/ack handshake with
// configurable wait states, word-organised little-endian RAM, lane select and extension.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  len_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] MEM_INIT = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    localparam logic [2:0] LEN_BS = 3'b001;
    localparam logic [2:0] LEN_BU = 3'b010;
    localparam logic [2:0] LEN_HS = 3'b011;
    localparam logic [2:0] LEN_HU = 3'b100;
    localparam logic [2:0] LEN_W  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  len_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [0:DEPTH-1] = '{default: MEM_INIT};

    // In IDLE the live request is decoded so a zero-wait access can finish on its acceptance edge.
    logic                  cur_we;
    logic [2:0]            cur_len;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_err;
    logic [3:0]            be;
    logic [31:0]           wword;
    logic [31:0]           rd_word;
    logic [31:0]           sh;
    logic [31:0]           rdata_next;
    logic                  enter_resp;
    logic                  commit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_we    = we_q;
        cur_len   = len_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == S_IDLE) begin
            cur_we    = we_i;
            cur_len   = len_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
        end
    end

    always_comb begin
        cur_idx = cur_addr[ADDR_WIDTH+1:2];
        cur_err = (((cur_len == LEN_HS) || (cur_len == LEN_HU)) && cur_addr[0])
               || ((cur_len == LEN_W) && (cur_addr[1:0] != 2'b00))
               || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0)
               || (cur_len[2:1] == 2'b11);

        be    = 4'b0000;
        wword = cur_wdata;
        case (cur_len)
            LEN_BS, LEN_BU: begin
                be    = 4'b0001 << cur_addr[1:0];
                wword = {4{cur_wdata[7:0]}};
            end
            LEN_HS, LEN_HU: begin
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{cur_wdata[15:0]}};
            end
            LEN_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        rd_word    = mem[cur_idx];
        sh         = rd_word >> {cur_addr[1:0], 3'b000};
        rdata_next = 32'd0;
        if (!cur_we && !cur_err) begin
            case (cur_len)
                LEN_BS:  rdata_next = {{24{sh[7]}}, sh[7:0]};
                LEN_BU:  rdata_next = {24'd0, sh[7:0]};
                LEN_HS:  rdata_next = {{16{sh[15]}}, sh[15:0]};
                LEN_HU:  rdata_next = {16'd0, sh[15:0]};
                LEN_W:   rdata_next = sh;
                default: rdata_next = 32'd0;
            endcase
        end

        enter_resp = ((state == S_WAIT) && (cnt == 4'd0))
                  || ((state == S_IDLE) && req_i && (WAIT_CYCLES == 0));
        commit     = enter_resp && rst && cur_we && !cur_err;
    end

    // NOTE: the RAM has no reset; contents must survive rst, and a reset would also block RAM inference.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[cur_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            len_q   <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ack_o   <= 1'b0;
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o   <= 1'b0;
                    rdata_o <= 32'd0;
                    err_o   <= 1'b0;
                    if (req_i) begin
                        we_q    <= we_i;
                        len_q   <= len_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        busy_o  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            ack_o   <= 1'b1;
                            rdata_o <= rdata_next;
                            err_o   <= cur_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= S_RESP;
                        ack_o   <= 1'b1;
                        rdata_o <= rdata_next;
                        err_o   <= cur_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    ack_o   <= 1'b0;
                    rdata_o <= 32'd0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for most cases and a
// WAIT_CYCLES=0 instance for the zero-wait path.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  len;
    logic [31:0] addr, wdata;
    logic        ack, err, busy;
    logic [31:0] rdata;
    logic        req0, we0;
    logic [2:0]  len0;
    logic [31:0] addr0, wdata0;
    logic        ack0, err0, busy0;
    logic [31:0] rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .len_i(len), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .err_o(err), .busy_o(busy)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .len_i(len0), .addr_i(addr0),
        .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the main DUT idle; req drops right after acceptance.
    task automatic op(input string tag, input logic w, input logic [2:0] l, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        req = 1'b1; we = w; len = l; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " rdata"}, rdata, exp_rd);
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, " ack drop"}, {31'd0, ack}, 32'd0);
        check({tag, " rdata clear"}, rdata, 32'd0);
        check({tag, " busy idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic op0(input string tag, input logic w, input logic [2:0] l, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        req0 = 1'b1; we0 = w; len0 = l; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        req0 = 1'b0;
        lat = 1;
        while (!ack0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd1);
        check({tag, " rdata"}, rdata0, exp_rd);
        check({tag, " err"}, {31'd0, err0}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, " ack drop"}, {31'd0, ack0}, 32'd0);
    endtask

    initial begin
        int acks, lows, n;
        int ack_at [3];

        rst = 1'b0;
        req = 1'b0; we = 1'b0; len = 3'b000; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; len0 = 3'b000; addr0 = 32'd0; wdata0 = 32'd0;
        #2;
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        op("zero init", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0, 1'b0);

        // T1 / T2: word store, byte overlay, lane extraction with both extensions
        op("st word", 1'b1, 3'b101, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        op("ld word", 1'b0, 3'b101, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        op("st byte", 1'b1, 3'b001, 32'h12, 32'hAAAAAA55, 32'h0, 1'b0);
        op("ld word2", 1'b0, 3'b101, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);
        op("ld bs 13", 1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        op("ld hu 12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h0000DE55, 1'b0);
        op("ld bu 11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h000000BE, 1'b0);
        op("ld hs 10", 1'b0, 3'b011, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        op("ld bs 12", 1'b0, 3'b001, 32'h12, 32'h0, 32'h00000055, 1'b0);
        op("st half", 1'b1, 3'b011, 32'h16, 32'h77778001, 32'h0, 1'b0);
        op("ld w 14", 1'b0, 3'b101, 32'h14, 32'h0, 32'h80010000, 1'b0);
        op("ld hs 16", 1'b0, 3'b011, 32'h16, 32'h0, 32'hFFFF8001, 1'b0);

        // T3: misalignment, range and reserved-len errors; erroring stores must not write
        op("ld w mis", 1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1);
        op("ld h mis", 1'b0, 3'b011, 32'h13, 32'h0, 32'h0, 1'b1);
        op("st w mis", 1'b1, 3'b101, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        op("st b range", 1'b1, 3'b001, 32'h1010, 32'h00000000, 32'h0, 1'b1);
        op("ld unchanged", 1'b0, 3'b101, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);
        op("ld range", 1'b0, 3'b101, 32'h1000, 32'h0, 32'h0, 1'b1);
        op("ld rsvd len", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
        op("st w 18", 1'b1, 3'b101, 32'h18, 32'h11223344, 32'h0, 1'b0);

        // T4: req held across three loads; acks every WAIT_CYCLES+2 with one idle cycle between
        acks = 0; lows = 0;
        ack_at[0] = 0; ack_at[1] = 0; ack_at[2] = 0;
        req = 1'b1; we = 1'b0; len = 3'b101; addr = 32'h18;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c <= 11 && !busy) lows++;
            if (ack) begin
                if (acks < 3) ack_at[acks] = c;
                acks++;
                check("b2b rdata", rdata, 32'h11223344);
                if (acks == 3) req = 1'b0;
            end
        end
        check("b2b ack count", 32'(acks), 32'd3);
        check("b2b first ack", 32'(ack_at[0]), 32'd3);
        check("b2b spacing 1", 32'(ack_at[1] - ack_at[0]), 32'd4);
        check("b2b spacing 2", 32'(ack_at[2] - ack_at[1]), 32'd4);
        check("b2b idle cycles", 32'(lows), 32'd2);

        // T5: reset during WAIT drops the pending store and produces no ack
        op("st w 20", 1'b1, 3'b101, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        req = 1'b1; we = 1'b1; len = 3'b101; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort in wait", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #2;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort ack", {31'd0, ack}, 32'd0);
        #2 rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        check("abort no ack", 32'(n), 32'd0);
        op("ld after abort", 1'b0, 3'b101, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

        // T6: zero wait states and len=000
        op0("z st w", 1'b1, 3'b101, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0);
        op0("z ld w", 1'b0, 3'b101, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);
        op0("z ld bs", 1'b0, 3'b001, 32'h7, 32'h0, 32'hFFFFFFCA, 1'b0);
        op0("z len none", 1'b0, 3'b000, 32'h4, 32'h0, 32'h0, 1'b0);
        op0("z st none", 1'b1, 3'b000, 32'h4, 32'h0, 32'h0, 1'b0);
        op0("z ld after none", 1'b0, 3'b101, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
